// File: rtl/matmul_seq.sv
// Sequencer for C = A x B on an external PE: walks (i,j) in row-major order and streams k operand pairs per element.
// Optional busy-cycle counter is built only when MATMUL_SEQ_PERF_EN is defined.
module matmul_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_DIM    = 4
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               start_i,
   input  logic [$clog2(MAX_DIM+1)-1:0]       n_dim_i,
   input  logic [$clog2(MAX_DIM+1)-1:0]       k_dim_i,
   input  logic [$clog2(MAX_DIM+1)-1:0]       m_dim_i,
   input  logic                               stall_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               err_o,
   output logic                               rd_en_o,
   output logic [$clog2(MAX_DIM)-1:0]         a_row_o,
   output logic [$clog2(MAX_DIM)-1:0]         a_col_o,
   output logic [$clog2(MAX_DIM)-1:0]         b_row_o,
   output logic [$clog2(MAX_DIM)-1:0]         b_col_o,
   output logic                               pe_clr_o,
   output logic                               pe_acc_o,
   output logic                               c_wr_en_o,
   output logic [$clog2(MAX_DIM)-1:0]         c_row_o,
   output logic [$clog2(MAX_DIM)-1:0]         c_col_o,
   output logic [31:0]                        perf_cycles_o
);
   localparam int DIM_W = $clog2(MAX_DIM+1);
   localparam int IDX_W = $clog2(MAX_DIM);

   // Element width only documents the attached datapath; nothing here depends on it.
   if (DATA_WIDTH > 0) begin : g_data_width_ok
   end

   typedef enum logic [2:0] {IDLE, CLEAR, ACC, DRAIN, WRITE, DONE} state_t;

   state_t           state_reg, state_next;
   logic [DIM_W-1:0] n_reg, k_reg, m_reg, n_next, k_next, m_next;
   logic [IDX_W-1:0] i_reg, j_reg, l_reg, i_next, j_next, l_next;
   logic [IDX_W-1:0] a_row_reg, a_col_reg, b_col_reg, c_row_reg, c_col_reg;
   logic             err_reg, err_next, acc_reg;
   logic             rd_en, c_wr_en, pe_clr, dims_ok, last_l, last_j, last_i;

   assign dims_ok = (n_dim_i != '0) && (n_dim_i <= DIM_W'(MAX_DIM)) &&
                    (k_dim_i != '0) && (k_dim_i <= DIM_W'(MAX_DIM)) &&
                    (m_dim_i != '0) && (m_dim_i <= DIM_W'(MAX_DIM));
   assign last_l  = (DIM_W'(l_reg) + DIM_W'(1)) == k_reg;
   assign last_j  = (DIM_W'(j_reg) + DIM_W'(1)) == m_reg;
   assign last_i  = (DIM_W'(i_reg) + DIM_W'(1)) == n_reg;

   always_comb begin
      state_next = state_reg;
      n_next     = n_reg;
      k_next     = k_reg;
      m_next     = m_reg;
      i_next     = i_reg;
      j_next     = j_reg;
      l_next     = l_reg;
      err_next   = 1'b0;
      rd_en      = 1'b0;
      c_wr_en    = 1'b0;
      pe_clr     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               if (dims_ok) begin
                  n_next     = n_dim_i;
                  k_next     = k_dim_i;
                  m_next     = m_dim_i;
                  i_next     = '0;
                  j_next     = '0;
                  l_next     = '0;
                  state_next = CLEAR;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         CLEAR: begin
            if (!stall_i) begin
               pe_clr     = 1'b1;
               state_next = ACC;
            end
         end
         ACC: begin
            if (!stall_i) begin
               rd_en = 1'b1;
               if (last_l) begin
                  l_next     = '0;
                  state_next = DRAIN;
               end else begin
                  l_next = l_reg + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!stall_i) state_next = WRITE;
         end
         WRITE: begin
            if (!stall_i) begin
               c_wr_en    = 1'b1;
               state_next = CLEAR;
               if (last_j) begin
                  j_next = '0;
                  if (last_i) begin
                     i_next     = '0;
                     state_next = DONE;
                  end else begin
                     i_next = i_reg + 1'b1;
                  end
               end else begin
                  j_next = j_reg + 1'b1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
         n_reg     <= '0;
         k_reg     <= '0;
         m_reg     <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         l_reg     <= '0;
         err_reg   <= 1'b0;
         acc_reg   <= 1'b0;
         a_row_reg <= '0;
         a_col_reg <= '0;
         b_col_reg <= '0;
         c_row_reg <= '0;
         c_col_reg <= '0;
      end else begin
         state_reg <= state_next;
         n_reg     <= n_next;
         k_reg     <= k_next;
         m_reg     <= m_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         l_reg     <= l_next;
         err_reg   <= err_next;
         acc_reg   <= rd_en;
         if (rd_en) begin
            a_row_reg <= i_reg;
            a_col_reg <= l_reg;
            b_col_reg <= j_reg;
         end
         if (c_wr_en) begin
            c_row_reg <= i_reg;
            c_col_reg <= j_reg;
         end
      end
   end

   // Indices are live while their strobe is high and otherwise show the last issued value.
   assign busy_o    = (state_reg != IDLE);
   assign done_o    = (state_reg == DONE);
   assign err_o     = err_reg;
   assign rd_en_o   = rd_en;
   assign pe_clr_o  = pe_clr;
   assign pe_acc_o  = acc_reg;
   assign c_wr_en_o = c_wr_en;
   assign a_row_o   = rd_en ? i_reg : a_row_reg;
   assign a_col_o   = rd_en ? l_reg : a_col_reg;
   assign b_row_o   = rd_en ? l_reg : a_col_reg;
   assign b_col_o   = rd_en ? j_reg : b_col_reg;
   assign c_row_o   = c_wr_en ? i_reg : c_row_reg;
   assign c_col_o   = c_wr_en ? j_reg : c_col_reg;

`ifdef MATMUL_SEQ_PERF_EN
   logic [31:0] perf_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_reg <= '0;
      end else if (state_reg == IDLE && start_i && dims_ok) begin
         perf_reg <= '0;
      end else if (state_reg != IDLE && perf_reg != '1) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end

   assign perf_cycles_o = perf_reg;
`else
   assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Self-checking bench for matmul_seq: table of runs plus random runs, each checked against a
// loop-nest model of the expected operand/result index streams and cycle counts.
module tb_matmul_seq;
   localparam int MAX_DIM = 4;
   localparam int DIM_W   = 3;
   localparam int IDX_W   = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             stall = 1'b0;
   logic [DIM_W-1:0] n_dim = '0, k_dim = '0, m_dim = '0;
   logic             busy, done, err, rd_en, pe_clr, pe_acc, c_wr_en;
   logic [IDX_W-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
   logic [31:0]      perf;

   int n_vec = 0;
   int n_bad = 0;

   matmul_seq #(.DATA_WIDTH(32), .MAX_DIM(MAX_DIM)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start),
      .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim), .stall_i(stall),
      .busy_o(busy), .done_o(done), .err_o(err), .rd_en_o(rd_en),
      .a_row_o(a_row), .a_col_o(a_col), .b_row_o(b_row), .b_col_o(b_col),
      .pe_clr_o(pe_clr), .pe_acc_o(pe_acc), .c_wr_en_o(c_wr_en),
      .c_row_o(c_row), .c_col_o(c_col), .perf_cycles_o(perf)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_pe_clr"}, pe_clr, 0);
      chk({tag, "_pe_acc"}, pe_acc, 0);
      chk({tag, "_c_wr_en"}, c_wr_en, 0);
      chk({tag, "_ab_idx"}, {a_row, a_col, b_row, b_col}, 0);
      chk({tag, "_c_idx"}, {c_row, c_col}, 0);
      chk({tag, "_perf"}, perf, 0);
   endtask

   // One run: model builds the expected index streams from the loop nest i,j,l.
   task automatic run(input int n, input int k, input int m, input int smode,
                      input bit mid, input int exp_busy, input bit exp_err, input int id);
      int       q_rd[$];
      int       q_wr[$];
      bit       legal;
      int       busy_cnt = 0, err_cnt = 0, done_cnt = 0, clr_cnt = 0, acc_cnt = 0;
      int       stall_busy = 0, cyc = 0, exp_perf;
      logic     prev_rd;
      logic [7:0] prev_ab, cur_ab;
      logic [3:0] prev_c, cur_c;
      legal = (n >= 1 && n <= MAX_DIM) && (k >= 1 && k <= MAX_DIM) && (m >= 1 && m <= MAX_DIM);
      if (legal) begin
         for (int i = 0; i < n; i++)
            for (int j = 0; j < m; j++) begin
               for (int l = 0; l < k; l++) q_rd.push_back((i << 6) | (l << 4) | (l << 2) | j);
               q_wr.push_back((i << 2) | j);
            end
      end
      @(negedge clk);
      #1;
      prev_rd = rd_en;
      prev_ab = {a_row, a_col, b_row, b_col};
      prev_c  = {c_row, c_col};
      n_dim = DIM_W'(n); k_dim = DIM_W'(k); m_dim = DIM_W'(m);
      start = 1'b1;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (mid && cyc == 20) begin
            start = 1'b1; n_dim = 3'd1; k_dim = 3'd1; m_dim = 3'd1;
         end
         case (smode)
            1:       stall = (cyc >= 3 && cyc <= 5);
            2:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
         endcase
         #1;
         cur_ab = {a_row, a_col, b_row, b_col};
         cur_c  = {c_row, c_col};
         if (busy) begin
            busy_cnt++;
            if (stall && !done) stall_busy++;
         end
         err_cnt  += int'(err);
         done_cnt += int'(done);
         clr_cnt  += int'(pe_clr);
         acc_cnt  += int'(pe_acc);
         chk("pe_acc_lag", pe_acc, prev_rd);
         if (stall && busy && !done)
            chk("stall_strobes", {rd_en, c_wr_en, pe_clr}, 0);
         if (rd_en) begin
            if (q_rd.size() > 0) chk("rd_index", cur_ab, q_rd.pop_front());
            else                 chk("rd_extra", 1, 0);
         end else begin
            chk("ab_hold", cur_ab, prev_ab);
         end
         if (c_wr_en) begin
            if (q_wr.size() > 0) chk("wr_index", cur_c, q_wr.pop_front());
            else                 chk("wr_extra", 1, 0);
         end else begin
            chk("c_hold", cur_c, prev_c);
         end
         prev_rd = rd_en;
         prev_ab = cur_ab;
         prev_c  = cur_c;
         if (!busy && (busy_cnt > 0 || cyc >= 3)) break;
         if (cyc > 2000) begin
            chk("run_timeout", cyc, 0);
            break;
         end
      end
      stall = 1'b0;
      start = 1'b0;
`ifdef MATMUL_SEQ_PERF_EN
      exp_perf = legal ? busy_cnt : 0;
      if (!legal) exp_perf = int'(perf);
`else
      exp_perf = 0;
`endif
      if (exp_busy >= 0) chk("busy_table", busy_cnt, exp_busy);
      chk("busy_model", busy_cnt, legal ? n * m * (k + 3) + 1 + stall_busy : 0);
      chk("err_pulses", err_cnt, legal ? 0 : 1);
      chk("err_table", err_cnt, int'(exp_err));
      chk("done_pulses", done_cnt, legal ? 1 : 0);
      chk("rd_missing", q_rd.size(), 0);
      chk("wr_missing", q_wr.size(), 0);
      chk("clr_count", clr_cnt, legal ? n * m : 0);
      chk("acc_count", acc_cnt, legal ? n * m * k : 0);
      chk("perf_final", perf, exp_perf);
      $display("run %0d: n=%0d k=%0d m=%0d stall_mode=%0d busy=%0d err=%0d done=%0d perf=%0d",
               id, n, k, m, smode, busy_cnt, err_cnt, done_cnt, perf);
   endtask

   typedef struct {
      int n; int k; int m; int smode; bit mid; int exp_busy; bit exp_err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      tbl[0] = '{2, 2, 1, 0, 1'b0,  11, 1'b0};
      tbl[1] = '{2, 2, 1, 1, 1'b0,  14, 1'b0};
      tbl[2] = '{2, 0, 1, 0, 1'b0,   0, 1'b1};
      tbl[3] = '{5, 2, 1, 0, 1'b0,   0, 1'b1};
      tbl[4] = '{4, 4, 4, 0, 1'b1, 113, 1'b0};
      tbl[5] = '{1, 1, 1, 0, 1'b0,   5, 1'b0};
      tbl[6] = '{3, 1, 2, 0, 1'b0,  25, 1'b0};
      tbl[7] = '{1, 4, 4, 0, 1'b0,  29, 1'b0};
      tbl[8] = '{4, 1, 1, 0, 1'b0,  17, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk_all_zero("post_reset");

      for (int t = 0; t < 9; t++)
         run(tbl[t].n, tbl[t].k, tbl[t].m, tbl[t].smode, tbl[t].mid,
             tbl[t].exp_busy, tbl[t].exp_err, t);

      // Abort a 2x2x2 run while it is writing; everything must drop at once.
      begin
         int  wait_cyc = 0;
         int  late_done = 0;
         @(negedge clk);
         n_dim = 3'd2; k_dim = 3'd2; m_dim = 3'd2;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #1;
         while (!c_wr_en && wait_cyc < 100) begin
            @(negedge clk);
            #1;
            wait_cyc++;
         end
         chk("abort_saw_write", c_wr_en, 1);
         #1;
         rst_n = 1'b0;
         #1;
         chk_all_zero("abort");
         @(negedge clk);
         rst_n = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            late_done += int'(done) + int'(busy);
         end
         chk("abort_no_done", late_done, 0);
         $display("run abort: reset during WRITE after %0d cycles, late activity=%0d", wait_cyc, late_done);
      end
      run(2, 2, 2, 0, 1'b0, 21, 1'b0, 100);

      for (int r = 0; r < 10; r++)
         run(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
             2, 1'b0, -1, 1'b0, 200 + r);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, operand element width (pass-through documentation only, no datapath inside).
REQ-002 The block SHALL expose parameter MAX_DIM, default 4, largest legal value of any matrix dimension.
REQ-003 The block SHALL expose local parameter DIM_W = $clog2(MAX_DIM+1), width of dimension fields, and IDX_W = $clog2(MAX_DIM), width of index outputs.
REQ-004 Ports:
  clk_i  in  1  clock, all state on rising edge
  rst_ni  in  1  asynchronous, active-low reset
  start_i  in  1  request to begin one multiplication
  n_dim_i / k_dim_i / m_dim_i  in  DIM_W each  rows of A / cols of A = rows of B / cols of B, sampled with start_i
  stall_i  in  1  backpressure from operand memories or PE array
  busy_o  out  1  sequencer not idle
  done_o  out  1  one-cycle completion pulse
  err_o  out  1  one-cycle illegal-dimension pulse
  rd_en_o  out  1  operand read strobe for A and B
  a_row_o / a_col_o  out  IDX_W each  A element index (i,l)
  b_row_o / b_col_o  out  IDX_W each  B element index (l,j)
  pe_clr_o  out  1  clear PE accumulator
  pe_acc_o  out  1  accumulate the operand pair returned this cycle
  c_wr_en_o  out  1  result write strobe
  c_row_o / c_col_o  out  IDX_W each  C element index (i,j)
  perf_cycles_o  out  32  busy-cycle count (see Configuration)

Function
REQ-005 The FSM SHALL have states IDLE, CLEAR, ACC, DRAIN, WRITE, DONE; busy_o = (state != IDLE).
REQ-006 In IDLE, start_i=1 with all dims in 1..MAX_DIM SHALL latch dims, set i=j=l=0, go to CLEAR next cycle.
REQ-007 In IDLE, start_i=1 with any dim 0 or >MAX_DIM SHALL pulse err_o for exactly one cycle and stay IDLE.
REQ-008 start_i outside IDLE SHALL be ignored; latched dims SHALL not change during a run.
REQ-009 CLEAR SHALL last one cycle with pe_clr_o=1, then go to ACC.
REQ-010 ACC SHALL last k cycles; each cycle rd_en_o=1, a=(i,l), b=(l,j), l increments; after l=k-1 go to DRAIN.
REQ-011 pe_acc_o SHALL equal rd_en_o delayed one cycle (memory read latency 1), so last accumulate occurs in DRAIN.
REQ-012 WRITE SHALL last one cycle with c_wr_en_o=1, c=(i,j); then j increments; j wraps to 0 at m-1 and i increments; after (n-1,m-1) go to DONE, else CLEAR.
REQ-013 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-014 Unstalled run length SHALL be n*m*(k+3)+1 busy cycles.
REQ-015 stall_i=1 in CLEAR, ACC, DRAIN or WRITE SHALL freeze state and counters and force pe_clr_o, rd_en_o, c_wr_en_o to 0 that cycle; pe_acc_o follows REQ-011 on the gated strobe.
REQ-016 stall_i SHALL have no effect in IDLE and DONE.
REQ-017 Index outputs SHALL hold their last value when their strobe is low.

Reset
REQ-018 rst_ni=0 SHALL asynchronously force IDLE, all counters and latched dims to 0, and every output to 0, including mid-run; no done_o follows an aborted run.

Configuration
REQ-019 With macro MATMUL_SEQ_PERF_EN defined, perf_cycles_o SHALL clear on run acceptance, increment every busy cycle including stalls, saturate at 2^32-1, and hold after DONE.
REQ-020 Without MATMUL_SEQ_PERF_EN, perf_cycles_o SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-021 n=2,k=2,m=1, no stall -> busy_o 11 cycles, c_wr_en_o at (0,0) then (1,0), done_o once, perf_cycles_o=11 with macro.
REQ-022 Same run, stall_i high 3 cycles mid-ACC -> no strobe during stall, indices unchanged, busy_o 14 cycles, perf_cycles_o=14.
REQ-023 start_i with k=0, then n=5 (MAX_DIM=4) -> err_o one-cycle pulse each, busy_o stays 0.
REQ-024 n=m=k=4 -> 16 writes in row-major order, 113 busy cycles; start_i pulsed mid-run ignored.
REQ-025 rst_ni low during WRITE of n=2,k=2,m=2 run -> all outputs 0 immediately; next start_i runs cleanly from (0,0).
REQ-026 Build without MATMUL_SEQ_PERF_EN, run REQ-021 -> perf_cycles_o=0 throughout, other outputs identical.
